wb_port_arbiter: RTL
====================

// Module: wb_port_arbiter
// PURPOSE
//  Shares one scoreboard writeback port between NR_REQ functional-unit result producers (e.g. mult, csr, fpu, lsu-load).
//  - Each requester hands over {trans_id, data, exception} through valid/ready into a private 1-entry holding buffer.
//  - A round-robin scheduler drains one buffer per cycle onto the shared wb port.
//  - Sits between the execute-stage FUs and the issue stage's wb_valid_i/trans_id_i/wbdata_i/ex_ex_i inputs.
// PARAMETERS
//  NR_REQ          4    number of requesters sharing the port (2..8)
//  CNT_WIDTH       32   width of per-requester stall counters (perf option only)
// PORTS
//  clk_i           in   1                       clock
//  rst_i           in   1                       reset, synchronous, active-high
//  flush_i         in   1                       drop all buffered results (pipeline flush)
//  req_valid_i     in   NR_REQ                  requester i offers a result
//  req_ready_o     out  NR_REQ                  requester i result accepted this cycle
//  req_trans_id_i  in   NR_REQ x TRANS_ID_BITS  scoreboard tag per requester
//  req_data_i      in   NR_REQ x 64             result data per requester
//  req_ex_i        in   NR_REQ x exception_t    exception per requester
//  wb_valid_o      out  1                       writeback valid to scoreboard
//  wb_trans_id_o   out  TRANS_ID_BITS           writeback tag
//  wb_data_o       out  64                      writeback data
//  wb_ex_o         out  exception_t             writeback exception
//  stall_cnt_o     out  NR_REQ x CNT_WIDTH      per-requester lost-arbitration cycle counts
// BEHAVIOUR
//  - Reset (rst_i=1 at clock edge): all buffers empty, rr_q=0, counters 0.
//    - After reset, wb_valid_o=0; wb_trans_id_o/wb_data_o/wb_ex_o=0; stall_cnt_o=0.
//  - The scoreboard never back-pressures: any wb_valid_o=1 cycle is consumed.
//  - Buffer i state: buf_valid[i] plus payload.
//    - req_ready_o[i] = !flush_i && (!buf_valid[i] || gnt[i]).
//    - Handshake: req_valid_i[i] && req_ready_o[i] loads the payload at the edge; buf_valid[i] <= 1.
//    - Else if gnt[i]: buf_valid[i] <= 0.
//  - Latency: a result accepted at edge t is eligible in cycle t+1; no combinational fall-through from req_*_i to wb_*_o.
//  - Arbitration (combinational over buf_valid):
//    - gnt = first valid index scanning rr_q, rr_q+1, ... mod NR_REQ; wrap-around included.
//    - wb_valid_o = |buf_valid && !flush_i; wb_* payload = buffer[gnt], else all-zero.
//    - On any grant: rr_q <= (gnt_idx+1) mod NR_REQ. With no grant, rr_q holds.
//  - Simultaneous drain + refill of the same buffer: buffer reloads with new payload, stays valid, and loses priority for one round.
//  - Throughput: 1 result/cycle aggregate.
//    - A single streaming requester gets 1 result/cycle.
//    - Worst-case wait for any valid buffer is NR_REQ-1 cycles (starvation-free).
//  - Flush: with flush_i=1, wb_valid_o=0 and req_ready_o=0 that cycle.
//    - All buf_valid clear at the edge; rr_q unchanged.
//  - Reset mid-operation overrides flush and handshakes; buffered results are discarded.
//  - An exception is passed unchanged with its payload; exception results are never treated specially or reordered.
// CONFIGURATION
//  - Macro WB_ARB_PERF_EN defined:
//    - stall_cnt_o[i] increments by 1 each cycle buf_valid[i] && !gnt[i] && !flush_i.
//    - Counters saturate at all-ones and clear only on reset.
//  - Macro WB_ARB_PERF_EN undefined: counters not built; stall_cnt_o tied to 0.
// STRUCTURE
//  - ariane_pkg gains typedef wb_arb_entry_t {logic [TRANS_ID_BITS-1:0] trans_id; logic [63:0] data; exception_t ex;}.
//    - The holding buffers and the wb_* output mux use this type.
//  - exception_t and TRANS_ID_BITS come from ariane_pkg.
//  - Sub-module wb_rr_picker: purely combinational NR_REQ-wide find-first-from-pointer.
//    - Inputs: valid vector, pointer.
//    - Outputs: one-hot grant, index, any-valid.
//    - Reusable by other arbiters in the execute stage.
//  - Buffers, rr_q and counters live in wb_port_arbiter.
// TESTING
//  - Reset: rst_i=1 with req_valid_i=4'b1111 -> wb_valid_o=0, req_ready_o=4'b0000 not required.
//    - Cycle after release: buffers empty, req_ready_o=4'b1111.
//  - Single requester: req 2 sends trans_id=3, data=0xDEAD at edge t -> cycle t+1 shows wb_valid_o=1, trans_id=3, data=0xDEAD.
//    - Cycle t+2: wb_valid_o=0 if no further request.
//  - Fairness/wrap: all four buffers loaded same cycle with rr_q=0 -> grants 0,1,2,3 on consecutive cycles.
//    - Refill buffer 0 at the first grant -> 5th grant is 0 (wrap); rr_q sequence 1,2,3,0,1.
//  - Drain+refill: requester 1 streams trans_id 1,2,3 back-to-back alone -> wb_trans_id_o 1,2,3 on consecutive cycles.
//    - req_ready_o[1] stays 1 throughout.
//  - Flush: buffers 0 and 3 valid, flush_i=1 for one cycle -> wb_valid_o=0 that cycle and the next.
//    - Buffered trans_ids are never written back.
//  - Perf (WB_ARB_PERF_EN): requesters 0 and 1 both stream continuously for 10 cycles.
//    - stall_cnt_o[0] and stall_cnt_o[1] each equal 5 (+/-1).
//    - Without the macro, stall_cnt_o reads 0.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the writeback port arbiter: scoreboard tag width, exception record
// and the holding-buffer entry that travels from a functional unit to the writeback port.
package wb_port_arbiter_pkg;

    localparam int TRANS_ID_BITS = 3;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [63:0]              data;
        exception_t               ex;
    } wb_arb_entry_t;

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin picker: first set bit of valid_i scanning upward from ptr_i,
// wrapping around. Returns a one-hot grant, its index and whether anything was valid.
module wb_rr_picker #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int pos;

    // Scan from farthest to nearest so the entry closest to the pointer wins last.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        pos   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = (int'(ptr_i) + k) % N;
            if (valid_i[pos]) begin
                gnt_o      = '0;
                gnt_o[pos] = 1'b1;
                idx_o      = IW'(pos);
                any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares one scoreboard writeback port between NR_REQ result producers through 1-entry
// holding buffers and a round-robin drain. Optional stall counters: define WB_ARB_PERF_EN.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int NR_REQ    = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic [NR_REQ-1:0]        req_valid_i,
    output logic [NR_REQ-1:0]        req_ready_o,
    input  logic [TRANS_ID_BITS-1:0] req_trans_id_i [NR_REQ],
    input  logic [63:0]              req_data_i     [NR_REQ],
    input  exception_t               req_ex_i       [NR_REQ],
    output logic                     wb_valid_o,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic [63:0]              wb_data_o,
    output exception_t               wb_ex_o,
    output logic [CNT_WIDTH-1:0]     stall_cnt_o    [NR_REQ]
);

    localparam int IW = $clog2(NR_REQ);

    logic [NR_REQ-1:0] buf_valid;
    wb_arb_entry_t     buf_q [NR_REQ];
    logic [IW-1:0]     rr_q;
    logic [NR_REQ-1:0] pick_gnt;
    logic [NR_REQ-1:0] gnt;
    logic [IW-1:0]     gnt_idx;
    logic              pick_any;
    logic              grant;
    wb_arb_entry_t     wb_entry;

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] idx);
        return (int'(idx) == NR_REQ - 1) ? '0 : idx + 1'b1;
    endfunction

    wb_rr_picker #(.N(NR_REQ)) i_picker (
        .valid_i (buf_valid),
        .ptr_i   (rr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (gnt_idx),
        .any_o   (pick_any)
    );

    // A flush suppresses the grant so rr_q and the drained buffer are left untouched.
    assign grant       = pick_any && !flush_i;
    assign gnt         = grant ? pick_gnt : '0;
    assign req_ready_o = flush_i ? '0 : (~buf_valid | gnt);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_valid <= '0;
            rr_q      <= '0;
        end else begin
            if (flush_i) begin
                buf_valid <= '0;
            end else begin
                for (int i = 0; i < NR_REQ; i++) begin
                    if (req_valid_i[i] && req_ready_o[i]) begin
                        buf_valid[i] <= 1'b1;
                    end else if (gnt[i]) begin
                        buf_valid[i] <= 1'b0;
                    end
                end
            end
            if (grant) begin
                rr_q <= next_ptr(gnt_idx);
            end
        end
    end

    // Payload registers carry no reset; buf_valid alone qualifies them.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NR_REQ; i++) begin
            if (req_valid_i[i] && req_ready_o[i]) begin
                buf_q[i] <= '{trans_id: req_trans_id_i[i], data: req_data_i[i], ex: req_ex_i[i]};
            end
        end
    end

    always_comb begin
        wb_entry = '0;
        if (grant) begin
            wb_entry = buf_q[gnt_idx];
        end
    end

    assign wb_valid_o    = grant;
    assign wb_trans_id_o = wb_entry.trans_id;
    assign wb_data_o     = wb_entry.data;
    assign wb_ex_o       = wb_entry.ex;

`ifdef WB_ARB_PERF_EN
    logic [CNT_WIDTH-1:0] cnt_q [NR_REQ];

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NR_REQ; i++) begin
            if (rst_i) begin
                cnt_q[i] <= '0;
            end else if (buf_valid[i] && !gnt[i] && !flush_i) begin
                cnt_q[i] <= sat_inc(cnt_q[i]);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NR_REQ; i++) begin
            stall_cnt_o[i] = cnt_q[i];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NR_REQ; i++) begin
            stall_cnt_o[i] = '0;
        end
    end
`endif

endmodule
